// File: rtl/tag_pkg.sv
// Shared widths and types for the tag busy table.
package tag_pkg;

  localparam int unsigned TAG_W   = 4;
  localparam int unsigned ENTRIES = 2 ** TAG_W;
  localparam int unsigned CNT_W   = TAG_W + 1;
  localparam int unsigned PORTS   = 2;

  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [ENTRIES-1:0] tag_mask_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  // Number of set bits in a tag mask.
  function automatic cnt_t popcount(input tag_mask_t m);
    cnt_t acc;
    acc = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      acc = acc + CNT_W'(m[TAG_W'(i)]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/decoder4_to_16.sv
// Binary tag to one-hot mask; all zero when not enabled.
module decoder4_to_16
  import tag_pkg::*;
(
  input  logic [TAG_W-1:0]   i_data,
  input  logic               i_en,
  output logic [ENTRIES-1:0] o_data
);

  always_comb begin
    o_data = '0;
    if (i_en) begin
      o_data[i_data] = 1'b1;
    end
  end

endmodule

// File: rtl/tag_busy_table.sv
// Busy/free tracking for in-flight tags: two allocs and two releases per cycle,
// occupancy, lookup ports and a two-lowest-free finder for the allocator.
module tag_busy_table
  import tag_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic [PORTS-1:0]       i_alloc_vld,
  input  tag_t [PORTS-1:0]       i_alloc_tag,
  input  logic [PORTS-1:0]       i_free_vld,
  input  tag_t [PORTS-1:0]       i_free_tag,
  input  tag_t [PORTS-1:0]       i_query_tag,
  output logic [PORTS-1:0]       o_query_busy,
  output logic [ENTRIES-1:0]     o_busy_vec,
  output logic [CNT_W-1:0]       o_busy_cnt,
  output logic                   o_full,
  output logic                   o_empty,
  output tag_t [PORTS-1:0]       o_free_tag,
  output logic [PORTS-1:0]       o_free_vld,
  output logic                   o_err
);

  tag_mask_t [PORTS-1:0] alloc_oh;
  tag_mask_t [PORTS-1:0] free_oh;
  tag_mask_t             set_c;
  tag_mask_t             clr_c;
  tag_mask_t             busy_nxt_c;
  cnt_t                  cnt_nxt_c;
  logic                  err_nxt_c;

  tag_mask_t             busy_q;
  cnt_t                  cnt_q;
  logic                  full_q;
  logic                  empty_q;
  logic                  err_q;

  for (genvar p = 0; p < PORTS; p++) begin : g_dec
    decoder4_to_16 u_alloc_dec (
      .i_data (i_alloc_tag[p]),
      .i_en   (i_alloc_vld[p]),
      .o_data (alloc_oh[p])
    );
    decoder4_to_16 u_free_dec (
      .i_data (i_free_tag[p]),
      .i_en   (i_free_vld[p]),
      .o_data (free_oh[p])
    );
  end

  // Next vector: allocation takes priority over a release of the same tag.
  always_comb begin
    set_c      = alloc_oh[0] | alloc_oh[1];
    clr_c      = free_oh[0] | free_oh[1];
    busy_nxt_c = (busy_q & ~clr_c) | set_c;
    if (i_flush) begin
      busy_nxt_c = '0;
    end
    cnt_nxt_c = popcount(busy_nxt_c);
  end

  // Protocol checks against the current registered vector; suppressed by flush.
  always_comb begin
    err_nxt_c = 1'b0;
    if (i_alloc_vld[0] && busy_q[i_alloc_tag[0]] && !clr_c[i_alloc_tag[0]]) begin
      err_nxt_c = 1'b1;
    end
    if (i_alloc_vld[1] && busy_q[i_alloc_tag[1]] && !clr_c[i_alloc_tag[1]]) begin
      err_nxt_c = 1'b1;
    end
    if ((i_alloc_vld == 2'b11) && (i_alloc_tag[0] == i_alloc_tag[1])) begin
      err_nxt_c = 1'b1;
    end
    if (i_free_vld[0] && !busy_q[i_free_tag[0]]) begin
      err_nxt_c = 1'b1;
    end
    if (i_free_vld[1] && !busy_q[i_free_tag[1]]) begin
      err_nxt_c = 1'b1;
    end
    if (i_flush) begin
      err_nxt_c = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_nxt_c;
      cnt_q   <= cnt_nxt_c;
      full_q  <= (cnt_nxt_c == CNT_W'(ENTRIES));
      empty_q <= (cnt_nxt_c == '0);
      err_q   <= err_nxt_c;
    end
  end

  // Two lowest free tags, scanned upward from tag 0.
  always_comb begin
    tag_t idx;
    idx        = '0;
    o_free_tag = '0;
    o_free_vld = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      idx = TAG_W'(i);
      if (!busy_q[idx]) begin
        if (!o_free_vld[0]) begin
          o_free_tag[0] = idx;
          o_free_vld[0] = 1'b1;
        end else if (!o_free_vld[1]) begin
          o_free_tag[1] = idx;
          o_free_vld[1] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_query_busy[0] = busy_q[i_query_tag[0]];
    o_query_busy[1] = busy_q[i_query_tag[1]];
  end

  assign o_busy_vec = busy_q;
  assign o_busy_cnt = cnt_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_tag_busy_table.sv
// Randomized scoreboard bench for tag_busy_table against an array-based model.
module tb_tag_busy_table;
  import tag_pkg::*;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_flush;
  logic [1:0]       i_alloc_vld;
  tag_t [1:0]       i_alloc_tag;
  logic [1:0]       i_free_vld;
  tag_t [1:0]       i_free_tag;
  tag_t [1:0]       i_query_tag;
  logic [1:0]       o_query_busy;
  logic [15:0]      o_busy_vec;
  logic [4:0]       o_busy_cnt;
  logic             o_full;
  logic             o_empty;
  tag_t [1:0]       o_free_tag;
  logic [1:0]       o_free_vld;
  logic             o_err;

  typedef struct {
    logic [15:0] vec;
    logic [4:0]  cnt;
    logic        full;
    logic        empty;
    logic        err;
    logic [3:0]  ft0;
    logic [3:0]  ft1;
    logic [1:0]  fvld;
    logic [1:0]  qb;
  } exp_t;

  exp_t sbq[$];
  bit   mb[16];
  int   n_cmp  = 0;
  int   n_fail = 0;

  tag_busy_table dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_flush      (i_flush),
    .i_alloc_vld  (i_alloc_vld),
    .i_alloc_tag  (i_alloc_tag),
    .i_free_vld   (i_free_vld),
    .i_free_tag   (i_free_tag),
    .i_query_tag  (i_query_tag),
    .o_query_busy (o_query_busy),
    .o_busy_vec   (o_busy_vec),
    .o_busy_cnt   (o_busy_cnt),
    .o_full       (o_full),
    .o_empty      (o_empty),
    .o_free_tag   (o_free_tag),
    .o_free_vld   (o_free_vld),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected visible outputs for the model state, queried at tags q0/q1.
  function automatic exp_t model_view(input int q0, input int q1, input bit err);
    exp_t e;
    int   n;
    int   nfree;
    e     = '{default: '0};
    n     = 0;
    nfree = 0;
    for (int i = 0; i < 16; i++) begin
      if (mb[i]) begin
        n++;
      end else begin
        if (nfree == 0) e.ft0 = 4'(i);
        if (nfree == 1) e.ft1 = 4'(i);
        nfree++;
      end
      e.vec = e.vec | (16'(mb[i]) << i);
    end
    e.cnt   = 5'(n);
    e.full  = (n == 16);
    e.empty = (n == 0);
    e.fvld  = {nfree >= 2, nfree >= 1};
    e.err   = err;
    e.qb    = {mb[q1], mb[q0]};
    return e;
  endfunction

  // One cycle of stimulus: checks the pre-edge lookups, updates the model, queues the result.
  task automatic step(input bit fl, input bit [1:0] av, input int a0, input int a1,
                      input bit [1:0] fv, input int f0, input int f1,
                      input int q0, input int q1);
    exp_t pre;
    bit   nb[16];
    bit   er;
    i_flush        = fl;
    i_alloc_vld    = av;
    i_alloc_tag[0] = 4'(a0);
    i_alloc_tag[1] = 4'(a1);
    i_free_vld     = fv;
    i_free_tag[0]  = 4'(f0);
    i_free_tag[1]  = 4'(f1);
    i_query_tag[0] = 4'(q0);
    i_query_tag[1] = 4'(q1);
    #1;
    pre = model_view(q0, q1, 1'b0);
    chk("pre_query_busy", 32'(o_query_busy), 32'(pre.qb));
    chk("pre_free_tag", {24'd0, o_free_tag[1], o_free_tag[0]}, {24'd0, pre.ft1, pre.ft0});
    er = 1'b0;
    if (fl) begin
      foreach (nb[i]) nb[i] = 1'b0;
    end else begin
      if (av[0] && mb[a0] && !((fv[0] && f0 == a0) || (fv[1] && f1 == a0))) er = 1'b1;
      if (av[1] && mb[a1] && !((fv[0] && f0 == a1) || (fv[1] && f1 == a1))) er = 1'b1;
      if (av == 2'b11 && a0 == a1) er = 1'b1;
      if (fv[0] && !mb[f0]) er = 1'b1;
      if (fv[1] && !mb[f1]) er = 1'b1;
      nb = mb;
      if (fv[0]) nb[f0] = 1'b0;
      if (fv[1]) nb[f1] = 1'b0;
      if (av[0]) nb[a0] = 1'b1;
      if (av[1]) nb[a1] = 1'b1;
    end
    mb = nb;
    sbq.push_back(model_view(q0, q1, er));
    @(negedge i_clk);
  endtask

  task automatic idle(input int q0, input int q1);
    step(1'b0, 2'b00, 0, 0, 2'b00, 0, 0, q0, q1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vec"}, 32'(o_busy_vec), 32'h0);
    chk({tag, "_cnt"}, 32'(o_busy_cnt), 32'h0);
    chk({tag, "_empty"}, 32'(o_empty), 32'h1);
    chk({tag, "_full"}, 32'(o_full), 32'h0);
    chk({tag, "_err"}, 32'(o_err), 32'h0);
    chk({tag, "_free_tag"}, {24'd0, o_free_tag[1], o_free_tag[0]}, 32'h10);
    chk({tag, "_free_vld"}, 32'(o_free_vld), 32'h3);
    chk({tag, "_qbusy"}, 32'(o_query_busy), 32'h0);
  endtask

  // Monitor: pops one expectation per clock shortly after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("busy_vec", 32'(o_busy_vec), 32'(e.vec));
        chk("busy_cnt", 32'(o_busy_cnt), 32'(e.cnt));
        chk("full", 32'(o_full), 32'(e.full));
        chk("empty", 32'(o_empty), 32'(e.empty));
        chk("err", 32'(o_err), 32'(e.err));
        chk("free_tag", {24'd0, o_free_tag[1], o_free_tag[0]}, {24'd0, e.ft1, e.ft0});
        chk("free_vld", 32'(o_free_vld), 32'(e.fvld));
        chk("query_busy", 32'(o_query_busy), 32'(e.qb));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, f0, f1;
    bit [1:0] av, fv;
    i_rst_n     = 1'b0;
    i_flush     = 1'b0;
    i_alloc_vld = '0;
    i_alloc_tag = '0;
    i_free_vld  = '0;
    i_free_tag  = '0;
    i_query_tag = '0;
    foreach (mb[i]) mb[i] = 1'b0;
    repeat (2) @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Alloc 3 and 9, then release 3.
    step(0, 2'b11, 3, 9, 2'b00, 0, 0, 3, 9);
    chk("dir_alloc_3_9", 32'(o_busy_vec), 32'h0208);
    step(0, 2'b00, 0, 0, 2'b01, 3, 0, 3, 9);
    chk("dir_free_3", 32'(o_busy_vec), 32'h0200);

    // Fill, then alloc+free of the same tag while full, then a bad alloc.
    step(1, 2'b11, 1, 2, 2'b11, 3, 4, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 2'b11, 2 * i, 2 * i + 1, 2'b00, 0, 0, i, 15 - i);
    chk("dir_full", 32'(o_full), 32'h1);
    step(0, 2'b01, 5, 0, 2'b01, 5, 0, 5, 6);
    chk("dir_full_swap_err", 32'(o_err), 32'h0);
    step(0, 2'b01, 5, 0, 2'b00, 0, 0, 5, 6);
    chk("dir_full_alloc_err", 32'(o_err), 32'h1);
    chk("dir_full_vec", 32'(o_busy_vec), 32'hFFFF);

    // Flush overrides strobes, then a duplicate alloc from empty.
    step(1, 2'b01, 2, 0, 2'b01, 4, 0, 2, 4);
    chk("dir_flush_vec", 32'(o_busy_vec), 32'h0);
    step(0, 2'b11, 7, 7, 2'b00, 0, 0, 7, 0);
    chk("dir_dup_vec", 32'(o_busy_vec), 32'h0080);
    chk("dir_dup_err", 32'(o_err), 32'h1);
    idle(7, 0);
    chk("dir_dup_err_pulse", 32'(o_err), 32'h0);

    // Lookups with 0x000B, then a release of a free tag.
    step(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b11, 0, 1, 2'b00, 0, 0, 0, 0);
    step(0, 2'b01, 3, 0, 2'b00, 0, 0, 1, 2);
    chk("dir_qbusy", 32'(o_query_busy), 32'h1);
    chk("dir_free_2_4", {24'd0, o_free_tag[1], o_free_tag[0]}, 32'h42);
    step(0, 2'b00, 0, 0, 2'b01, 12, 0, 1, 2);
    chk("dir_free12_err", 32'(o_err), 32'h1);
    chk("dir_free12_vec", 32'(o_busy_vec), 32'h000B);

    // Empty: releasing is an error and the vector stays clear.
    step(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 2'b10, 0, 6, 6, 0);
    chk("dir_empty_err", 32'(o_err), 32'h1);

    // Randomized traffic with occasional flush and asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2;
        i_rst_n = 1'b0;
        #1;
        foreach (mb[i]) mb[i] = 1'b0;
        check_reset_outputs("mid_reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
      end
      av = 2'($urandom);
      fv = 2'($urandom);
      a0 = (($urandom & 1) != 0) ? int'(o_free_tag[0]) : int'($urandom_range(0, 15));
      a1 = (($urandom & 1) != 0) ? int'(o_free_tag[1]) : int'($urandom_range(0, 15));
      f0 = $urandom_range(0, 15);
      f1 = $urandom_range(0, 15);
      if (($urandom & 3) != 0) begin
        for (int k = 0; k < 16; k++) if (mb[(f0 + k) % 16]) begin f0 = (f0 + k) % 16; break; end
      end
      step(($urandom_range(0, 39) == 0), av, a0, a1, fv, f0, f1,
           $urandom_range(0, 15), $urandom_range(0, 15));
    end

    @(negedge i_clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
